// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: per-stage hold/bubble controls.
// Optional performance counters are built when PIPE_HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  IMEM_BUSY_WAIT,
    input  logic                  DMEM_BUSY_WAIT,
    input  logic                  BRANCH_RES,
    input  logic [2:0]            ID_EX_MEM_READ,
    input  logic [REG_ADDR_W-1:0] ID_EX_RD,
    input  logic [REG_ADDR_W-1:0] IF_ID_RS1,
    input  logic [REG_ADDR_W-1:0] IF_ID_RS2,
    output logic                  PC_HOLD,
    output logic                  PC_SEL_TARGET,
    output logic                  IF_ID_HOLD,
    output logic                  ID_EX_HOLD,
    output logic                  EX_MEM_HOLD,
    output logic                  MEM_WB_HOLD,
    output logic                  IF_ID_FLUSH,
    output logic                  ID_EX_FLUSH,
    output logic                  EX_MEM_FLUSH,
    output logic [CNT_W-1:0]      STALL_CYCLES,
    output logic [CNT_W-1:0]      FLUSH_COUNT,
    output logic [CNT_W-1:0]      LOAD_USE_COUNT
);

    typedef enum logic {
        RUN           = 1'b0,
        REDIRECT_PEND = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic   lu_done;
    logic   lu_fire;
    logic   load_use;

    // LU_DONE masks the hazard so the same instruction gets only one bubble.
    assign load_use = (ID_EX_MEM_READ != 3'd0) && (ID_EX_RD != '0) &&
                      ((ID_EX_RD == IF_ID_RS1) || (ID_EX_RD == IF_ID_RS2)) &&
                      !lu_done;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= RUN;
            lu_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            lu_done <= lu_fire;
        end
    end

    always_comb begin
        state_nxt     = state;
        lu_fire       = 1'b0;
        PC_HOLD       = 1'b0;
        PC_SEL_TARGET = 1'b0;
        IF_ID_HOLD    = 1'b0;
        ID_EX_HOLD    = 1'b0;
        EX_MEM_HOLD   = 1'b0;
        MEM_WB_HOLD   = 1'b0;
        IF_ID_FLUSH   = 1'b0;
        ID_EX_FLUSH   = 1'b0;
        EX_MEM_FLUSH  = 1'b0;

        if (RESET) begin
            state_nxt    = RUN;
            PC_HOLD      = 1'b1;
            IF_ID_HOLD   = 1'b1;
            ID_EX_HOLD   = 1'b1;
            EX_MEM_HOLD  = 1'b1;
            MEM_WB_HOLD  = 1'b1;
            IF_ID_FLUSH  = 1'b1;
            ID_EX_FLUSH  = 1'b1;
            EX_MEM_FLUSH = 1'b1;
        end else if (DMEM_BUSY_WAIT) begin
            // Whole pipe freezes; a branch seen now is remembered, not lost.
            PC_HOLD     = 1'b1;
            IF_ID_HOLD  = 1'b1;
            ID_EX_HOLD  = 1'b1;
            EX_MEM_HOLD = 1'b1;
            MEM_WB_HOLD = 1'b1;
            if (BRANCH_RES) begin
                state_nxt = REDIRECT_PEND;
            end
        end else if (BRANCH_RES || (state == REDIRECT_PEND)) begin
            IF_ID_FLUSH  = 1'b1;
            ID_EX_FLUSH  = 1'b1;
            EX_MEM_FLUSH = 1'b1;
            if (IMEM_BUSY_WAIT) begin
                PC_HOLD   = 1'b1;
                state_nxt = REDIRECT_PEND;
            end else begin
                PC_SEL_TARGET = 1'b1;
                state_nxt     = RUN;
            end
        end else if (IMEM_BUSY_WAIT) begin
            PC_HOLD     = 1'b1;
            IF_ID_HOLD  = 1'b1;
            ID_EX_FLUSH = 1'b1;
        end else if (load_use) begin
            PC_HOLD     = 1'b1;
            IF_ID_HOLD  = 1'b1;
            ID_EX_FLUSH = 1'b1;
            lu_fire     = 1'b1;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_q, flush_q, lu_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_q <= '0;
            flush_q <= '0;
            lu_q    <= '0;
        end else begin
            if (PC_HOLD) begin
                stall_q <= stall_q + 1'b1;
            end
            if (PC_SEL_TARGET) begin
                flush_q <= flush_q + 1'b1;
            end
            if (lu_fire) begin
                lu_q <= lu_q + 1'b1;
            end
        end
    end

    assign STALL_CYCLES   = stall_q;
    assign FLUSH_COUNT    = flush_q;
    assign LOAD_USE_COUNT = lu_q;
`else
    assign STALL_CYCLES   = '0;
    assign FLUSH_COUNT    = '0;
    assign LOAD_USE_COUNT = '0;
`endif

endmodule
